// File: rtl/store_buffer_pkg.sv
// Shared memory-stage definitions: store-op bit positions, wen encodings,
// the default store-buffer depth and the buffered entry layout.
package store_buffer_pkg;

    // Bit positions inside the one-hot st_op vector {swl,swr,sb,sh,sw}
    localparam int unsigned OP_SW  = 0;
    localparam int unsigned OP_SH  = 1;
    localparam int unsigned OP_SB  = 2;
    localparam int unsigned OP_SWR = 3;
    localparam int unsigned OP_SWL = 4;

    localparam int unsigned SB_DEPTH_DEFAULT = 4;

    // Byte write-enable encodings
    localparam logic [3:0] WEN_NONE  = 4'b0000;
    localparam logic [3:0] WEN_BYTE0 = 4'b0001;
    localparam logic [3:0] WEN_HALF0 = 4'b0011;
    localparam logic [3:0] WEN_HALF1 = 4'b1100;
    localparam logic [3:0] WEN_LOW3  = 4'b0111;
    localparam logic [3:0] WEN_HIGH3 = 4'b1110;
    localparam logic [3:0] WEN_BYTE3 = 4'b1000;
    localparam logic [3:0] WEN_WORD  = 4'b1111;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side bus of the store buffer: store/load requests in, SRAM port,
// stall and empty status out.
interface store_buffer_if;

    logic        flush;
    logic        st_valid;
    logic [4:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        stallreq_for_sb;
    logic        sb_empty;

    modport master (
        output flush, st_valid, st_op, st_addr, st_data, ld_valid, ld_addr,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  stallreq_for_sb, sb_empty
    );

    modport slave (
        input  flush, st_valid, st_op, st_addr, st_data, ld_valid, ld_addr,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output stallreq_for_sb, sb_empty
    );

endinterface

// File: rtl/store_align.sv
// Store formatter: turns a store op, its low address bits and the rt value
// into the byte write enables and lane-aligned write data.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [4:0]  st_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o
);

    // Priority chain instead of unique case: st_op may be all-zero when idle
    always_comb begin
        wen_o   = WEN_NONE;
        wdata_o = 32'h0;
        if (st_op_i[OP_SW]) begin
            wen_o   = WEN_WORD;
            wdata_o = st_data_i;
        end else if (st_op_i[OP_SB]) begin
            wen_o   = WEN_BYTE0 << addr_lo_i;
            wdata_o = {4{st_data_i[7:0]}};
        end else if (st_op_i[OP_SH]) begin
            // Misaligned halfword writes nothing
            wen_o   = addr_lo_i[0] ? WEN_NONE : (addr_lo_i[1] ? WEN_HALF1 : WEN_HALF0);
            wdata_o = {2{st_data_i[15:0]}};
        end else if (st_op_i[OP_SWL]) begin
            case (addr_lo_i)
                2'b00:   begin wen_o = WEN_BYTE0; wdata_o = st_data_i >> 24; end
                2'b01:   begin wen_o = WEN_HALF0; wdata_o = st_data_i >> 16; end
                2'b10:   begin wen_o = WEN_LOW3;  wdata_o = st_data_i >> 8;  end
                default: begin wen_o = WEN_WORD;  wdata_o = st_data_i;       end
            endcase
        end else if (st_op_i[OP_SWR]) begin
            case (addr_lo_i)
                2'b00:   begin wen_o = WEN_WORD;  wdata_o = st_data_i;       end
                2'b01:   begin wen_o = WEN_HIGH3; wdata_o = st_data_i << 8;  end
                2'b10:   begin wen_o = WEN_HALF1; wdata_o = st_data_i << 16; end
                default: begin wen_o = WEN_BYTE3; wdata_o = st_data_i << 24; end
            endcase
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the memory stage and the data SRAM. Loads
// own the SRAM port; buffered stores drain one per cycle otherwise. A load
// hitting a pending word stalls until that word has been written.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           resetn,
    store_buffer_if.slave  sb_bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    sb_entry_t        entries_q [DEPTH];

    logic      full, push, pop, ld_conflict, ld_go;
    logic      st_req;
    sb_entry_t new_entry, head_entry;

    store_align u_align (
        .st_op_i   (sb_bus.st_op),
        .addr_lo_i (sb_bus.st_addr[1:0]),
        .st_data_i (sb_bus.st_data),
        .wen_o     (new_entry.wen),
        .wdata_o   (new_entry.wdata)
    );

    assign new_entry.waddr = sb_bus.st_addr[31:2];
    assign head_entry      = entries_q[head_q];

    assign st_req = sb_bus.st_valid & ~sb_bus.flush;
    // Full is strict: a pop in the same cycle does not make room
    assign full   = (count_q == CntFull);
    assign push   = st_req & ~full;

    // Load conflicts with any pending entry that writes the same word
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && entries_q[i].waddr == sb_bus.ld_addr[31:2] &&
                entries_q[i].wen != WEN_NONE) begin
                ld_conflict = 1'b1;
            end
        end
        ld_conflict = ld_conflict & sb_bus.ld_valid;
    end

    // Load goes out unless it conflicts; a conflicting load lets the head drain
    assign ld_go = sb_bus.ld_valid & ~ld_conflict & resetn;
    assign pop   = ~ld_go & (count_q != '0);

    // Next-state for pointers, occupancy and per-entry valid bits
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q + CntW'(push) - CntW'(pop);
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
    end

    // Control state, cleared asynchronously; pending entries are discarded
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by valid_q
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q] <= new_entry;
        end
    end

    // SRAM port arbitration: load first, then drain the head, else idle zeros
    always_comb begin
        sb_bus.data_sram_en    = 1'b0;
        sb_bus.data_sram_wen   = WEN_NONE;
        sb_bus.data_sram_addr  = 32'h0;
        sb_bus.data_sram_wdata = 32'h0;
        if (ld_go) begin
            sb_bus.data_sram_en   = 1'b1;
            sb_bus.data_sram_addr = sb_bus.ld_addr;
        end else if (pop) begin
            sb_bus.data_sram_en    = 1'b1;
            sb_bus.data_sram_wen   = head_entry.wen;
            sb_bus.data_sram_addr  = {head_entry.waddr, 2'b00};
            sb_bus.data_sram_wdata = head_entry.wdata;
        end
    end

    assign sb_bus.stallreq_for_sb = (st_req & full) | ld_conflict;
    assign sb_bus.sb_empty        = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with hand-computed expected values.
module tb_store_buffer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    store_buffer_if sb_if ();

    store_buffer #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb_bus (sb_if)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] OpSw  = 5'b00001;
    localparam logic [4:0] OpSh  = 5'b00010;
    localparam logic [4:0] OpSb  = 5'b00100;
    localparam logic [4:0] OpSwr = 5'b01000;
    localparam logic [4:0] OpSwl = 5'b10000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_st(input logic v, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] d);
        sb_if.st_valid = v;
        sb_if.st_op    = op;
        sb_if.st_addr  = a;
        sb_if.st_data  = d;
    endtask

    task automatic check_port(input string tag, input logic en, input logic [3:0] wen,
                              input logic [31:0] a, input logic [31:0] d);
        check({tag, ".en"},    32'(sb_if.data_sram_en),  32'(en));
        check({tag, ".wen"},   32'(sb_if.data_sram_wen), 32'(wen));
        check({tag, ".addr"},  sb_if.data_sram_addr,     a);
        check({tag, ".wdata"}, sb_if.data_sram_wdata,    d);
    endtask

    initial begin
        sb_if.flush    = 1'b0;
        sb_if.ld_valid = 1'b0;
        sb_if.ld_addr  = 32'h0;
        set_st(1'b0, 5'b0, 32'h0, 32'h0);

        // Reset state
        #12;
        check("rst.empty", 32'(sb_if.sb_empty), 32'd1);
        check("rst.stall", 32'(sb_if.stallreq_for_sb), 32'd0);
        check_port("rst", 1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // sb to 0x1003: written the cycle after enqueue
        set_st(1'b1, OpSb, 32'h0000_1003, 32'h0000_00AB);
        settle();
        check("sb.same_cycle_en", 32'(sb_if.data_sram_en), 32'd0);
        step();
        set_st(1'b0, 5'b0, 32'h0, 32'h0);
        settle();
        check_port("sb", 1'b1, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB);
        check("sb.nonempty", 32'(sb_if.sb_empty), 32'd0);
        step();
        check("sb.empty_again", 32'(sb_if.sb_empty), 32'd1);
        check("sb.idle_en", 32'(sb_if.data_sram_en), 32'd0);

        // swl then swr to 0x2001
        set_st(1'b1, OpSwl, 32'h0000_2001, 32'h1122_3344);
        step();
        set_st(1'b1, OpSwr, 32'h0000_2001, 32'h1122_3344);
        settle();
        check_port("swl", 1'b1, 4'b0011, 32'h0000_2000, 32'h0000_1122);
        step();
        set_st(1'b0, 5'b0, 32'h0, 32'h0);
        settle();
        check_port("swr", 1'b1, 4'b1110, 32'h0000_2000, 32'h2233_4400);
        step();

        // sh to upper half of 0x5002
        set_st(1'b1, OpSh, 32'h0000_5002, 32'h1234_ABCD);
        step();
        set_st(1'b0, 5'b0, 32'h0, 32'h0);
        settle();
        check_port("sh", 1'b1, 4'b1100, 32'h0000_5000, 32'hABCD_ABCD);
        step();

        // Five stores behind a held load: the fifth stalls on full
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 32'h0000_9000;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, OpSw, 32'h0000_4000 + 32'(4 * i), 32'hA0 + 32'(i));
            settle();
            check("fill.stall", 32'(sb_if.stallreq_for_sb), 32'd0);
            check_port("fill.load", 1'b1, 4'b0000, 32'h0000_9000, 32'h0);
            step();
        end
        set_st(1'b1, OpSw, 32'h0000_4010, 32'hA4);
        settle();
        check("full.stall", 32'(sb_if.stallreq_for_sb), 32'd1);
        sb_if.ld_valid = 1'b0;
        settle();
        check("full.stall_on_pop", 32'(sb_if.stallreq_for_sb), 32'd1);
        check_port("drain0", 1'b1, 4'b1111, 32'h0000_4000, 32'hA0);
        step();
        check("drain.stall_clear", 32'(sb_if.stallreq_for_sb), 32'd0);
        check_port("drain1", 1'b1, 4'b1111, 32'h0000_4004, 32'hA1);
        step();
        set_st(1'b0, 5'b0, 32'h0, 32'h0);
        settle();
        check_port("drain2", 1'b1, 4'b1111, 32'h0000_4008, 32'hA2);
        step();
        check_port("drain3", 1'b1, 4'b1111, 32'h0000_400C, 32'hA3);
        step();
        check_port("drain4", 1'b1, 4'b1111, 32'h0000_4010, 32'hA4);
        step();
        check("drain.empty", 32'(sb_if.sb_empty), 32'd1);

        // Load hitting a pending word: store drains first, then the load
        set_st(1'b1, OpSw, 32'h0000_3000, 32'h55);
        step();
        set_st(1'b0, 5'b0, 32'h0, 32'h0);
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 32'h0000_3002;
        settle();
        check("conf.stall", 32'(sb_if.stallreq_for_sb), 32'd1);
        check_port("conf.store", 1'b1, 4'b1111, 32'h0000_3000, 32'h55);
        step();
        check("conf.stall_clear", 32'(sb_if.stallreq_for_sb), 32'd0);
        check_port("conf.load", 1'b1, 4'b0000, 32'h0000_3002, 32'h0);
        sb_if.ld_valid = 1'b0;
        step();

        // Flushed store is dropped
        sb_if.flush = 1'b1;
        set_st(1'b1, OpSw, 32'h0000_6000, 32'h66);
        settle();
        check("flush.empty", 32'(sb_if.sb_empty), 32'd1);
        step();
        check("flush.empty_next", 32'(sb_if.sb_empty), 32'd1);
        check("flush.en", 32'(sb_if.data_sram_en), 32'd0);
        sb_if.flush = 1'b0;
        set_st(1'b0, 5'b0, 32'h0, 32'h0);

        // Reset with three pending entries
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 32'h0000_9000;
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, OpSw, 32'h0000_7000 + 32'(4 * i), 32'h70 + 32'(i));
            step();
        end
        set_st(1'b0, 5'b0, 32'h0, 32'h0);
        sb_if.ld_valid = 1'b0;
        settle();
        check_port("pre_rst", 1'b1, 4'b1111, 32'h0000_7000, 32'h70);
        resetn = 1'b0;
        settle();
        check("mid_rst.empty", 32'(sb_if.sb_empty), 32'd1);
        check("mid_rst.en", 32'(sb_if.data_sram_en), 32'd0);
        check("mid_rst.stall", 32'(sb_if.stallreq_for_sb), 32'd0);
        step();
        resetn = 1'b1;
        step();
        check("post_rst.empty", 32'(sb_if.sb_empty), 32'd1);
        check("post_rst.en", 32'(sb_if.data_sram_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  kills this cycle's store request; entries already buffered are kept.
REQ-005 SHALL have port st_valid  input  1  a committed store is presented this cycle.
REQ-006 SHALL have port st_op  input  5  one-hot store type {swl,swr,sb,sh,sw}.
REQ-007 SHALL have port st_addr  input  32  store byte address.
REQ-008 SHALL have port st_data  input  32  rt value to be stored.
REQ-009 SHALL have port ld_valid  input  1  a load requests the SRAM port this cycle.
REQ-010 SHALL have port ld_addr  input  32  load byte address.
REQ-011 SHALL have port data_sram_en  output  1  SRAM access enable.
REQ-012 SHALL have port data_sram_wen  output  4  SRAM byte write enables.
REQ-013 SHALL have port data_sram_addr  output  32  SRAM address.
REQ-014 SHALL have port data_sram_wdata  output  32  SRAM write data.
REQ-015 SHALL have port stallreq_for_sb  output  1  pipeline stall request.
REQ-016 SHALL have port sb_empty  output  1  high when no entries are pending.

Function
REQ-017 SHALL be a circular FIFO with head and tail pointers plus an occupancy count of width log2(DEPTH)+1; the pointers wrap modulo DEPTH.
REQ-018 SHALL enqueue when st_valid & ~flush & ~full, storing the word address st_addr[31:2] together with the formatted wen and wdata.
REQ-019 SHALL format sw as wen 1111, wdata st_data.
REQ-020 SHALL format sb as wen 0001<<addr[1:0], wdata {4{st_data[7:0]}}.
REQ-021 SHALL format sh as wen 0011 at addr[1]=0 or 1100 at addr[1]=1, wdata {2{st_data[15:0]}}; addr[0]=1 SHALL give wen 0000.
REQ-022 SHALL format swl, for addr[1:0]=00/01/10/11, as wen 0001/0011/0111/1111 with wdata st_data>>24/>>16/>>8/>>0.
REQ-023 SHALL format swr, for addr[1:0]=00/01/10/11, as wen 1111/1110/1100/1000 with wdata st_data<<0/<<8/<<16/<<24.
REQ-024 SHALL drive the SRAM port for a load when ld_valid=1: en=1, wen=0000, addr=ld_addr, wdata=0; the load always has priority and draining pauses.
REQ-025 SHALL drain the head entry when ld_valid=0 and count>0: en=1, wen/wdata from the head entry, addr={head word address,2'b00}; the entry is popped at the next edge, one entry per cycle.
REQ-026 SHALL drive the SRAM outputs combinationally from the current state and inputs; with ld_valid=0 and the FIFO empty, all SRAM outputs SHALL be 0.
REQ-027 SHALL make a stored entry reach the SRAM no earlier than the cycle after its enqueue.
REQ-028 SHALL treat full as a strict condition: no enqueue while count==DEPTH, even if a pop occurs in the same cycle.
REQ-029 SHALL allow a simultaneous enqueue and pop, leaving count unchanged.
REQ-030 SHALL assert stallreq_for_sb when (st_valid & ~flush & full) or ld_conflict.
REQ-031 SHALL define ld_conflict as ld_valid with a valid entry whose word address equals ld_addr[31:2] and whose wen is nonzero.
REQ-032 SHALL, on ld_conflict, suppress the load: the port drains the head instead, so the conflict eventually clears; no data merging is performed.
REQ-033 SHALL drive sb_empty = (count==0), combinationally.

Reset
REQ-034 SHALL, on resetn=0 at any time including mid-drain, clear the pointers, count and entry-valid state asynchronously; entries pending at reset are discarded.
REQ-035 SHALL, while in reset, drive data_sram_en=0, wen=0 when ld_valid=0, stallreq_for_sb=0 when st_valid=0 and ld_valid=0, and sb_empty=1.

Structure
REQ-036 SHALL place the st_op bit positions, the DEPTH default and the wen encodings in the shared defines header used by the memory stage.
REQ-037 SHALL implement the formatting of REQ-019..023 in one combinational sub-module, store_align; the FIFO and port arbitration live in store_buffer.

Verification
REQ-038 SHALL cover: sb to 0x1003 with data 0x000000AB, idle -> next cycle en=1, wen=1000, addr 0x1000, wdata 0xABABABAB; sb_empty returns to 1.
REQ-039 SHALL cover: swl to 0x2001 and swr to 0x2001 with data 0x11223344 -> wen 0011, wdata 0x00001122; then wen 1110, wdata 0x22334400.
REQ-040 SHALL cover: 5 back-to-back sw with ld_valid held high -> the 5th store gives stallreq_for_sb=1 with count=4; release the load -> 4 writes in order, then the 5th is accepted.
REQ-041 SHALL cover: pending sw to 0x3000 and a load of 0x3002 -> stallreq_for_sb=1, port writes 0x3000 first, and the load is issued the following cycle.
REQ-042 SHALL cover: st_valid with flush=1 -> no enqueue and sb_empty stays 1.
REQ-043 SHALL cover: resetn pulsed low with 3 entries pending -> immediately sb_empty=1 and data_sram_en=0.
